lsu_mem_initiator: RTL and testbench
====================================

// Module: lsu_mem_initiator
// PURPOSE
//  Load/store initiator on the NPC data-memory port; the requester side of the
//  valid/raddr/mem_wen/waddr/wmask/wdata/rdata memory interface.
//  Accepts one load/store at a time from the execute stage and aligns it to a word.
//  Issues the memory access, then returns the extended load data or the store completion.
//  Misaligned accesses are rejected with an error and never reach memory.
// PARAMETERS
//  MEM_LAT  1  cycles mem_valid is held before mem_rdata is sampled (>=1)
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  req_valid   in   1   request from execute stage
//  req_ready   out  1   high only in IDLE; request accepted when valid&ready
//  req_wen     in   1   1=store, 0=load
//  req_size    in   2   00=byte, 01=half, 10=word, 11=illegal
//  req_unsgn   in   1   load zero-extend (1) / sign-extend (0)
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-justified
//  resp_valid  out  1   response available; held until resp_ready
//  resp_ready  in   1   consumer accepts response
//  resp_rdata  out  32  extended load data (0 for stores/errors)
//  resp_err    out  1   misaligned or illegal size
//  mem_valid   out  1   memory access active
//  mem_raddr   out  32  word address {addr[31:2],2'b00}
//  mem_wen     out  1   write strobe, one cycle per store
//  mem_waddr   out  32  word address {addr[31:2],2'b00}
//  mem_wmask   out  8   byte enables, [7:4] always 0
//  mem_wdata   out  32  lane-shifted store data
//  mem_rdata   in   32  word read data from memory
// BEHAVIOUR
//  Asynchronous reset: state=IDLE, counter=0.
//  Outputs during and after reset: req_ready=1, resp_valid=0, resp_err=0 and mem_valid=0.
//  All other outputs (resp_rdata, mem_raddr, mem_wen, mem_waddr, mem_wmask, mem_wdata) are 0.
//  FSM IDLE->REQ->RESP->IDLE. All request fields are registered on accept.
//  IDLE: on accept, check alignment.
//   -> RESP with err=1 if size==11, or size==01 with addr[0]!=0, or size==10 with addr[1:0]!=0.
//   -> otherwise REQ.
//  REQ: mem_valid=1 for exactly MEM_LAT cycles.
//   -> mem_raddr and mem_waddr are both driven; mem_wen=1 only in the first REQ cycle for stores.
//   -> mem_wmask=0 in all other cycles, so memory never sees a repeated write.
//   -> Loads sample mem_rdata at the edge ending the last REQ cycle.
//  Lane rules, with o=addr[1:0]:
//   -> wmask[3:0]: byte 4'b0001<<o, half 4'b0011<<o, word 4'b1111.
//   -> wdata = req_wdata<<(8*o). Load: d = rdata>>(8*o).
//   -> byte -> {24{unsgn?0:d[7]},d[7:0]}; half -> {16{unsgn?0:d[15]},d[15:0]}.
//  RESP: resp_valid=1 with stable rdata/err until resp_ready; then IDLE the next cycle.
//  Latency accept->resp_valid = MEM_LAT+1 cycles (1 cycle for errors).
//  Throughput: at most one request per MEM_LAT+2 cycles.
//  req_valid while busy: ignored (ready=0); no queueing.
//  Reset mid-REQ: access aborted, mem_valid/mem_wen drop immediately (async).
//  A store already strobed is not undone.
//  Address wrap: no carry past bit 31; addr 0xFFFFFFFC word is legal.
// TESTING
//  T1 store word 0xDEADBEEF @0x80000004 -> one cycle of mem_wen with waddr 0x80000004.
//     wmask 0x0F and wdata 0xDEADBEEF in that cycle; resp_valid after 2 cycles, err=0.
//  T2 store byte 0xA5 @0x80000003 -> wmask 0x08, wdata 0xA5000000; mem_wen high exactly 1 cycle.
//  T3 mem word 0x8081F2F3 @0x80000000: signed byte load @+1 -> 0xFFFFFFF2.
//     Unsigned half load @+2 -> 0x00008081.
//  T4 half load @0x80000001 -> resp_err=1 one cycle after accept; mem_valid never asserted.
//  T5 MEM_LAT=3, load held with resp_ready=0 for 5 cycles.
//     -> mem_valid high for 3 cycles; resp stable; req_ready=0 until the cycle after resp_ready.
//  T6 rst_n low in the second REQ cycle -> outputs take reset values immediately.
//     After release, the next request completes normally.

Source files
------------

// File: rtl/lsu_mem_initiator_if.sv
// Execute-stage request/response channel plus the NPC data-memory port.
// master = the load/store initiator, slave = execute stage and memory.
interface lsu_mem_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_unsgn;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic [31:0] mem_raddr;
  logic        mem_wen;
  logic [31:0] mem_waddr;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_wen, req_size, req_unsgn, req_addr, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_valid, mem_raddr, mem_wen, mem_waddr, mem_wmask, mem_wdata
  );

  modport slave (
    output req_valid, req_wen, req_size, req_unsgn, req_addr, req_wdata,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_valid, mem_raddr, mem_wen, mem_waddr, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Single-outstanding load/store initiator: word-aligns a request, holds the memory
// access for MEM_LAT cycles, and returns extended load data or store completion.

// One byte lane: store byte-enable/data for the incoming request, load byte for the
// registered offset.
module lsu_mem_lane #(
  parameter int LANE      = 0,
  parameter int NUM_LANES = 4,
  parameter int VEC_W     = 8
) (
  input  logic [$clog2(NUM_LANES)-1:0]    st_off,
  input  logic [1:0]                      st_size,
  input  logic [NUM_LANES-1:0][VEC_W-1:0] st_data,
  input  logic [$clog2(NUM_LANES)-1:0]    ld_off,
  input  logic [NUM_LANES-1:0][VEC_W-1:0] ld_data,
  output logic                            wmask,
  output logic [VEC_W-1:0]                wbyte,
  output logic [VEC_W-1:0]                rbyte
);
  localparam int OW = $clog2(NUM_LANES);
  localparam logic [OW:0] LANE_I = LANE[OW:0];

  logic [OW:0] st_src, ld_src, st_hi;

  // Bit OW of the source index flags a lane shifted in from outside the word.
  assign st_src = LANE_I - {1'b0, st_off};
  assign ld_src = LANE_I + {1'b0, ld_off};
  assign st_hi  = {1'b0, st_off} + {{OW{1'b0}}, 1'b1};

  assign wbyte = st_src[OW] ? '0 : st_data[st_src[OW-1:0]];
  assign rbyte = ld_src[OW] ? '0 : ld_data[ld_src[OW-1:0]];

  always_comb begin
    wmask = 1'b0;
    case (st_size)
      2'b00:   wmask = (st_off == LANE_I[OW-1:0]);
      2'b01:   wmask = (st_off == LANE_I[OW-1:0]) | (st_hi == LANE_I);
      2'b10:   wmask = 1'b1;
      default: wmask = 1'b0;
    endcase
  end
endmodule

module lsu_mem_initiator #(
  parameter int MEM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lsu_mem_initiator_if.master  bus
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int CW        = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t                           state;
  logic [CW-1:0]                    cnt;
  logic                             r_wen;
  logic                             r_unsgn;
  logic [1:0]                       r_size;
  logic [1:0]                       r_off;
  logic [NUM_LANES-1:0]             st_mask;
  logic [NUM_LANES-1:0][VEC_W-1:0]  st_data;
  logic [NUM_LANES-1:0][VEC_W-1:0]  ld_bytes;
  logic [31:0]                      ld_word;
  logic [31:0]                      ld_ext;
  logic [31:0]                      word_addr;
  logic                             misalign;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lsu_mem_lane #(.LANE(i), .NUM_LANES(NUM_LANES), .VEC_W(VEC_W)) u_lane (
      .st_off  (bus.req_addr[1:0]),
      .st_size (bus.req_size),
      .st_data (bus.req_wdata),
      .ld_off  (r_off),
      .ld_data (bus.mem_rdata),
      .wmask   (st_mask[i]),
      .wbyte   (st_data[i]),
      .rbyte   (ld_bytes[i])
    );
  end

  assign ld_word   = ld_bytes;
  assign word_addr = {bus.req_addr[31:2], 2'b00};
  assign misalign  = (bus.req_size == 2'b11)
                   | ((bus.req_size == 2'b01) & bus.req_addr[0])
                   | ((bus.req_size == 2'b10) & (|bus.req_addr[1:0]));

  always_comb begin
    ld_ext = ld_word;
    case (r_size)
      2'b00:   ld_ext = {{24{~r_unsgn & ld_word[7]}},  ld_word[7:0]};
      2'b01:   ld_ext = {{16{~r_unsgn & ld_word[15]}}, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      r_wen          <= 1'b0;
      r_unsgn        <= 1'b0;
      r_size         <= 2'b00;
      r_off          <= 2'b00;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
      bus.mem_valid  <= 1'b0;
      bus.mem_wen    <= 1'b0;
      bus.mem_raddr  <= '0;
      bus.mem_waddr  <= '0;
      bus.mem_wmask  <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            r_wen         <= bus.req_wen;
            r_unsgn       <= bus.req_unsgn;
            r_size        <= bus.req_size;
            r_off         <= bus.req_addr[1:0];
            cnt           <= '0;
            bus.req_ready <= 1'b0;
            if (misalign) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else begin
              state         <= REQ;
              bus.mem_valid <= 1'b1;
              bus.mem_wen   <= bus.req_wen;
              bus.mem_raddr <= word_addr;
              bus.mem_waddr <= word_addr;
              bus.mem_wmask <= bus.req_wen ? {4'b0000, st_mask} : 8'h00;
              bus.mem_wdata <= bus.req_wen ? st_data : '0;
            end
          end
        end
        REQ: begin
          // The write strobe covers only the first REQ cycle.
          bus.mem_wen   <= 1'b0;
          bus.mem_wmask <= 8'h00;
          bus.mem_wdata <= '0;
          if (cnt == CNT_LAST) begin
            state          <= RESP;
            bus.mem_valid  <= 1'b0;
            bus.mem_raddr  <= '0;
            bus.mem_waddr  <= '0;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= r_wen ? 32'h0 : ld_ext;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: directed table, multi-cycle corner sequences and
// randomized requests against an address-arithmetic reference model.
module tb_lsu_mem_initiator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_wen = 1'b0, req_unsgn = 1'b0, resp_ready = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;

  lsu_mem_initiator_if if1 ();
  lsu_mem_initiator_if if3 ();

  lsu_mem_initiator #(.MEM_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  lsu_mem_initiator #(.MEM_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  assign if1.req_valid = req_valid & ~sel;
  assign if3.req_valid = req_valid & sel;
  assign if1.req_wen = req_wen;     assign if3.req_wen = req_wen;
  assign if1.req_size = req_size;   assign if3.req_size = req_size;
  assign if1.req_unsgn = req_unsgn; assign if3.req_unsgn = req_unsgn;
  assign if1.req_addr = req_addr;   assign if3.req_addr = req_addr;
  assign if1.req_wdata = req_wdata; assign if3.req_wdata = req_wdata;
  assign if1.resp_ready = resp_ready; assign if3.resp_ready = resp_ready;

  // Memory returns real data only in the last cycle of an access.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h8081_F2F3;
    if (a == 32'hFFFF_FFFC) return 32'h1357_9BDF;
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  int vc1, vc3;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin vc1 <= 0; vc3 <= 0; end
    else begin
      vc1 <= if1.mem_valid ? vc1 + 1 : 0;
      vc3 <= if3.mem_valid ? vc3 + 1 : 0;
    end
  assign if1.mem_rdata = (if1.mem_valid && vc1 == 0) ? mem_word(if1.mem_raddr) : 32'hBAD0_BAD0;
  assign if3.mem_rdata = (if3.mem_valid && vc3 == 2) ? mem_word(if3.mem_raddr) : 32'hBAD0_BAD0;

  logic        o_req_ready, o_resp_valid, o_resp_err, o_mem_valid, o_mem_wen;
  logic [31:0] o_resp_rdata, o_mem_raddr, o_mem_waddr, o_mem_wdata;
  logic [7:0]  o_mem_wmask;
  assign o_req_ready  = sel ? if3.req_ready  : if1.req_ready;
  assign o_resp_valid = sel ? if3.resp_valid : if1.resp_valid;
  assign o_resp_err   = sel ? if3.resp_err   : if1.resp_err;
  assign o_resp_rdata = sel ? if3.resp_rdata : if1.resp_rdata;
  assign o_mem_valid  = sel ? if3.mem_valid  : if1.mem_valid;
  assign o_mem_wen    = sel ? if3.mem_wen    : if1.mem_wen;
  assign o_mem_raddr  = sel ? if3.mem_raddr  : if1.mem_raddr;
  assign o_mem_waddr  = sel ? if3.mem_waddr  : if1.mem_waddr;
  assign o_mem_wmask  = sel ? if3.mem_wmask  : if1.mem_wmask;
  assign o_mem_wdata  = sel ? if3.mem_wdata  : if1.mem_wdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"},  32'(o_req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(o_resp_valid), 32'd0);
    chk({tag, "_resp_err"},   32'(o_resp_err), 32'd0);
    chk({tag, "_mem_valid"},  32'(o_mem_valid), 32'd0);
    chk({tag, "_mem_wen"},    32'(o_mem_wen), 32'd0);
    chk({tag, "_resp_rdata"}, o_resp_rdata, 32'd0);
    chk({tag, "_mem_raddr"},  o_mem_raddr, 32'd0);
    chk({tag, "_mem_waddr"},  o_mem_waddr, 32'd0);
    chk({tag, "_mem_wmask"},  32'(o_mem_wmask), 32'd0);
    chk({tag, "_mem_wdata"},  o_mem_wdata, 32'd0);
  endtask

  // Reference model: error rule, lane placement and extension by plain arithmetic.
  task automatic model(input logic wen, input logic [1:0] size, input logic unsgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic err, output logic [31:0] rdata,
                       output logic [7:0] mask, output logic [31:0] wd);
    int unsigned o, n;
    logic [31:0] d;
    o   = addr % 4;
    err = (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && o != 0);
    n   = (size == 0) ? 1 : (size == 1) ? 3 : 15;
    mask = 8'(n << o);
    wd   = wdata << (8 * o);
    rdata = 0;
    if (!wen && !err) begin
      d = mem_word(addr - o) >> (8 * o);
      if (size == 0) begin
        rdata = d % 256;
        if (!unsgn && rdata >= 128) rdata = rdata + 32'hFFFF_FF00;
      end else if (size == 1) begin
        rdata = d % 65536;
        if (!unsgn && rdata >= 32768) rdata = rdata + 32'hFFFF_0000;
      end else rdata = d;
    end
  endtask

  task automatic do_txn(input string nm, input logic s, input logic wen, input logic [1:0] size,
                        input logic unsgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input logic [7:0] exp_mask, input logic [31:0] exp_wd,
                        input int lat_cfg, input int hold);
    int lat, nvld, nwen, addr_bad, mask_bad, busy_rdy, stable_bad;
    logic [31:0] gwa, gwd, rv0, word;
    logic [7:0]  gwm;
    logic        e0;
    word = {addr[31:2], 2'b00};
    gwa = '0; gwd = '0; gwm = '0;
    @(negedge clk);
    sel = s;
    req_wen = wen; req_size = size; req_unsgn = unsgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1; resp_ready = 1'b0;
    #1 chk({nm, "_ready_idle"}, 32'(o_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Busy-time request with different fields must be ignored.
    req_addr = addr ^ 32'h0000_0013; req_size = ~size; req_unsgn = ~unsgn; req_wdata = ~wdata;
    lat = 1; nvld = 0; nwen = 0; addr_bad = 0; mask_bad = 0; busy_rdy = 0;
    while (!o_resp_valid && lat < 20) begin
      if (o_req_ready) busy_rdy++;
      if (o_mem_valid) begin
        nvld++;
        if (o_mem_raddr !== word || o_mem_waddr !== word) addr_bad++;
      end
      if (o_mem_wen) begin
        nwen++; gwa = o_mem_waddr; gwm = o_mem_wmask; gwd = o_mem_wdata;
      end else if (o_mem_wmask !== 8'h00) mask_bad++;
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), exp_err ? 32'd1 : 32'(lat_cfg + 1));
    chk({nm, "_mem_valid_cycles"}, 32'(nvld), exp_err ? 32'd0 : 32'(lat_cfg));
    chk({nm, "_mem_wen_cycles"}, 32'(nwen), (wen && !exp_err) ? 32'd1 : 32'd0);
    chk({nm, "_busy_ready"}, 32'(busy_rdy), 32'd0);
    chk({nm, "_addr"}, 32'(addr_bad), 32'd0);
    chk({nm, "_stray_wmask"}, 32'(mask_bad), 32'd0);
    chk({nm, "_mem_idle_at_resp"}, 32'(o_mem_valid), 32'd0);
    chk({nm, "_resp_err"}, 32'(o_resp_err), 32'(exp_err));
    chk({nm, "_resp_rdata"}, o_resp_rdata, exp_rdata);
    if (wen && !exp_err) begin
      chk({nm, "_waddr"}, gwa, word);
      chk({nm, "_wmask"}, 32'(gwm), 32'(exp_mask));
      chk({nm, "_wdata"}, gwd, exp_wd);
    end
    rv0 = o_resp_rdata; e0 = o_resp_err; stable_bad = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!o_resp_valid || o_resp_rdata !== rv0 || o_resp_err !== e0 || o_req_ready || o_mem_valid)
        stable_bad++;
    end
    chk({nm, "_resp_stable"}, 32'(stable_bad), 32'd0);
    resp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk({nm, "_resp_drop"}, 32'(o_resp_valid), 32'd0);
    chk({nm, "_ready_back"}, 32'(o_req_ready), 32'd1);
  endtask

  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic        unsgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  mask;
    logic [31:0] wd;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic        m_err;
    logic [31:0] m_rd, m_wd, r_addr;
    logic [7:0]  m_mask;
    logic        r_wen, r_uns, r_sel;
    logic [1:0]  r_size;
    int          rr;

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 1'b0, 32'h0, 8'h0F, 32'hDEAD_BEEF};
    tbl[1]  = '{1'b1, 2'd0, 1'b0, 32'h8000_0003, 32'h0000_00A5, 1'b0, 32'h0, 8'h08, 32'hA500_0000};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h8000_0001, 32'h0, 1'b0, 32'hFFFF_FFF2, 8'h00, 32'h0};
    tbl[3]  = '{1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'h0, 1'b0, 32'h0000_8081, 8'h00, 32'h0};
    tbl[4]  = '{1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0, 1'b0, 32'hFFFF_8081, 8'h00, 32'h0};
    tbl[5]  = '{1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'h0, 1'b0, 32'h0000_0080, 8'h00, 32'h0};
    tbl[6]  = '{1'b0, 2'd0, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'hFFFF_FFF3, 8'h00, 32'h0};
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h8081_F2F3, 8'h00, 32'h0};
    tbl[8]  = '{1'b0, 2'd1, 1'b0, 32'h8000_0001, 32'h0, 1'b1, 32'h0, 8'h00, 32'h0};
    tbl[9]  = '{1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'h0, 8'h00, 32'h0};
    tbl[10] = '{1'b1, 2'd2, 1'b0, 32'h8000_0002, 32'h1234_5678, 1'b1, 32'h0, 8'h00, 32'h0};
    tbl[11] = '{1'b1, 2'd1, 1'b0, 32'h1000_0002, 32'h0000_1234, 1'b0, 32'h0, 8'h0C, 32'h1234_0000};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h1357_9BDF, 8'h00, 32'h0};
    tbl[13] = '{1'b1, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0BAD_F00D, 1'b0, 32'h0, 8'h0F, 32'h0BAD_F00D};
    tbl[14] = '{1'b1, 2'd0, 1'b0, 32'h1000_0001, 32'hFFFF_FF5A, 1'b0, 32'h0, 8'h02, 32'hFFFF_5A00};

    repeat (2) @(negedge clk);
    sel = 1'b0; #1 chk_reset_vals("rst_in_lat1");
    sel = 1'b1; #1 chk_reset_vals("rst_in_lat3");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sel = 1'b0; #1 chk_reset_vals("rst_out_lat1");
    sel = 1'b1; #1 chk_reset_vals("rst_out_lat3");

    for (int i = 0; i < 15; i++)
      do_txn($sformatf("vec%0d", i), 1'b0, tbl[i].wen, tbl[i].size, tbl[i].unsgn, tbl[i].addr,
             tbl[i].wdata, tbl[i].err, tbl[i].rdata, tbl[i].mask, tbl[i].wd, 1, i % 3);

    // Long memory latency with a stalled consumer.
    do_txn("t5_lat3_hold", 1'b1, 1'b0, 2'd2, 1'b0, 32'h8000_0000, 32'h0,
           1'b0, 32'h8081_F2F3, 8'h00, 32'h0, 3, 5);
    do_txn("lat3_err", 1'b1, 1'b0, 2'd1, 1'b1, 32'h8000_0003, 32'h0,
           1'b1, 32'h0, 8'h00, 32'h0, 3, 2);

    // Reset asserted in the second REQ cycle of a store.
    @(negedge clk);
    sel = 1'b1; req_wen = 1'b1; req_size = 2'd2; req_unsgn = 1'b0;
    req_addr = 32'h2000_0010; req_wdata = 32'h1122_3344; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("t6_req_active", 32'(o_mem_valid), 32'd1);
    chk("t6_strobe_first", 32'(o_mem_wen), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    do_txn("t6_after", 1'b1, 1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'h0,
           1'b0, 32'h0000_0080, 8'h00, 32'h0, 3, 1);

    for (int k = 0; k < 40; k++) begin
      r_sel  = 1'($urandom_range(0, 1));
      r_wen  = 1'($urandom_range(0, 1));
      r_uns  = 1'($urandom_range(0, 1));
      rr     = int'($urandom_range(0, 9));
      r_size = (rr < 3) ? 2'd0 : (rr < 6) ? 2'd1 : (rr < 9) ? 2'd2 : 2'd3;
      r_addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (r_size == 2'd1) r_addr = r_addr & 32'hFFFF_FFFE;
        if (r_size == 2'd2) r_addr = r_addr & 32'hFFFF_FFFC;
      end
      if (k % 10 == 0) r_addr = 32'hFFFF_FFFC;
      model(r_wen, r_size, r_uns, r_addr, $urandom, m_err, m_rd, m_mask, m_wd);
      req_wdata = 32'h0;
      m_wd = $urandom;
      model(r_wen, r_size, r_uns, r_addr, m_wd, m_err, m_rd, m_mask, m_wd);
      do_txn($sformatf("rnd%0d", k), r_sel, r_wen, r_size, r_uns, r_addr,
             (m_wd >> (8 * (r_addr % 4))) | 32'h0, m_err, m_rd, m_mask, m_wd,
             r_sel ? 3 : 1, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
